// File: rtl/interrupt_controller_pkg.sv
// ----------------------------------------------------------------------------
// interrupt_controller_pkg
// Shared definitions for the interrupt controller slice:
//   - irq_state_e        : controller FSM state encoding (IDLE / REQ / SERVICE)
//   - DEF_NUM_IRQ        : default number of external request lines
//   - DEF_VECTOR_BASE    : default handler address of source 0
//   - DEF_VECTOR_STRIDE  : default spacing between handler vectors
//   - calc_vector()      : handler address for a given source index
// ----------------------------------------------------------------------------
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam int          DEF_NUM_IRQ       = 4;
    localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0000;
    localparam logic [15:0] DEF_VECTOR_STRIDE = 16'h0010;

    // Handler address = base + id * stride, computed wide and truncated to 16 bits.
    function automatic logic [15:0] calc_vector(input logic [15:0] base,
                                                input logic [15:0] stride,
                                                input logic [31:0] id);
        logic [31:0] addr;
        addr = {16'h0000, base} + (id * {16'h0000, stride});
        return addr[15:0];
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// ----------------------------------------------------------------------------
// irq_sync_edge
// Two-flop synchronizer followed by a rising-edge detector for one
// asynchronous interrupt request line.
//   clk       : processor clock
//   rst_n     : asynchronous active-low reset
//   irq_async : raw asynchronous request level
//   rise      : one-cycle pulse when a genuine low->high transition is seen
//
// The detector only arms after it has observed a real low sample coming out
// of the synchronizer. This way a line that is already high when reset is
// released does not look like a fresh edge; it has to drop and rise again.
// ----------------------------------------------------------------------------
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_async,
    output logic rise
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic       armed_q, armed_d;
    // fill_q[1] marks that sync2_q holds a real sample rather than reset value
    logic [1:0] fill_q,  fill_d;

    // Next-state for synchronizer, history and arming flops
    always_comb begin
        sync1_d = irq_async;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
    end

    // Synchronizer and edge-detector state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            fill_q  <= fill_d;
        end
    end

    assign rise = sync2_q & ~prev_q & armed_q;

endmodule

// File: rtl/interrupt_controller.sv
// ----------------------------------------------------------------------------
// interrupt_controller
// Edge-triggered, fixed-priority (index 0 highest), non-nesting interrupt
// controller with a per-source mask.
//   clk        : processor clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   irq_in     : asynchronous request lines, rising edge requests service
//   mask_we    : mask register write strobe
//   mask_data  : new mask value (1 = source disabled)
//   int_ack    : processor accepted the interrupt (honoured only in REQ)
//   int_done   : handler return retired (honoured only in SERVICE)
//   interrupt  : registered request to the processor
//   int_vector : registered handler address of the selected source
//   int_id     : registered index of the selected source
//   pending    : registered pending register
//   in_service : registered, high while a handler executes
// ----------------------------------------------------------------------------
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ       = DEF_NUM_IRQ,
    parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter logic [15:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE,
    localparam int         ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               interrupt,
    output logic [15:0]        int_vector,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               in_service
);

    irq_state_e         state_q,      state_d;
    logic [NUM_IRQ-1:0] pending_q,    pending_d;
    logic [NUM_IRQ-1:0] mask_q,       mask_d;
    logic [ID_W-1:0]    int_id_q,     int_id_d;
    logic [15:0]        int_vector_q, int_vector_d;
    logic               interrupt_q,  interrupt_d;
    logic               in_service_q, in_service_d;

    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] eligible_s;
    logic [NUM_IRQ-1:0] clear_s;
    logic [ID_W-1:0]    sel_s;
    logic               ack_take_s;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
        irq_sync_edge u_sync (
            .clk       (clk),
            .rst_n     (reset),
            .irq_async (irq_in[gi]),
            .rise      (rise_s[gi])
        );
    end

    assign eligible_s = pending_q & ~mask_q;
    assign ack_take_s = (state_q == ST_REQ) && int_ack;

    // Lowest-index eligible source; scanning downward lets index 0 win
    always_comb begin
        sel_s = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible_s[i]) begin
                sel_s = i[ID_W-1:0];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Mask write and pending set/clear; a coincident new edge beats the clear
    always_comb begin
        clear_s = '0;
        if (ack_take_s) begin
            clear_s[int_id_q] = 1'b1;
        end else begin
            clear_s = '0;
        end
        pending_d = (pending_q & ~clear_s) | rise_s;
        if (mask_we) begin
            mask_d = mask_data;
        end else begin
            mask_d = mask_q;
        end
    end

    // FSM next state; id/vector are latched only when leaving IDLE
    always_comb begin
        state_d      = state_q;
        int_id_d     = int_id_q;
        int_vector_d = int_vector_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible_s) begin
                    state_d      = ST_REQ;
                    int_id_d     = sel_s;
                    int_vector_d = calc_vector(VECTOR_BASE, VECTOR_STRIDE,
                                               {{(32-ID_W){1'b0}}, sel_s});
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d = ST_SERVICE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                // Returning to IDLE guarantees one idle cycle before next REQ
                if (int_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        interrupt_d  = (state_d == ST_REQ);
        in_service_d = (state_d == ST_SERVICE);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            mask_q       <= '0;
            int_id_q     <= '0;
            int_vector_q <= VECTOR_BASE;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            int_id_q     <= int_id_d;
            int_vector_q <= int_vector_d;
            interrupt_q  <= interrupt_d;
            in_service_q <= in_service_d;
        end
    end

    assign interrupt  = interrupt_q;
    assign int_vector = int_vector_q;
    assign int_id     = int_id_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// ----------------------------------------------------------------------------
// tb_interrupt_controller
// Directed bench. Stimulus pushes the expected {int_id, int_vector} of each
// request it provokes into a queue; a monitor pops and compares whenever the
// controller raises interrupt. State checks in between compare against
// hand-computed constants.
// ----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_data;
    logic        int_ack;
    logic        int_done;
    logic        interrupt;
    logic [15:0] int_vector;
    logic [1:0]  int_id;
    logic [3:0]  pending;
    logic        in_service;

    int tests;
    int fails;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] vec;
    } exp_t;

    exp_t exp_q[$];
    logic int_prev;

    interrupt_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_data  (mask_data),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .interrupt  (interrupt),
        .int_vector (int_vector),
        .int_id     (int_id),
        .pending    (pending),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [15:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    // one-cycle pulse; returns at the negedge after the sampling edge
    task automatic pulse_irq(input logic [3:0] v);
        @(negedge clk) irq_in = v;
        @(negedge clk) irq_in = 4'b0000;
    endtask

    task automatic do_ack();
        @(negedge clk) int_ack = 1'b1;
        @(negedge clk) int_ack = 1'b0;
    endtask

    task automatic do_done();
        @(negedge clk) int_done = 1'b1;
        @(negedge clk) int_done = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        @(negedge clk) begin
            mask_we   = 1'b1;
            mask_data = m;
        end
        @(negedge clk) mask_we = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_interrupt"},  {31'd0, interrupt},  32'd0);
        check({tag, "_in_service"}, {31'd0, in_service}, 32'd0);
        check({tag, "_pending"},    {28'd0, pending},    32'd0);
        check({tag, "_int_id"},     {30'd0, int_id},     32'd0);
        check({tag, "_int_vector"}, {16'd0, int_vector}, 32'h0000);
    endtask

    // Monitor: every new request is matched against the scoreboard queue
    always @(negedge clk) begin
        if (reset === 1'b1 && interrupt === 1'b1 && int_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_req: got id %0d vec %0h, expected no request", int_id, int_vector);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_int_id",     {30'd0, int_id},     {30'd0, e.id});
                check("mon_int_vector", {16'd0, int_vector}, {16'd0, e.vec});
            end
        end
        int_prev = interrupt;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests     = 0;
        fails     = 0;
        int_prev  = 1'b0;
        reset     = 1'b0;
        irq_in    = 4'b0000;
        mask_we   = 1'b0;
        mask_data = 4'b0000;
        int_ack   = 1'b0;
        int_done  = 1'b0;

        tick(3);
        check_reset_vals("rst");
        reset = 1'b1;
        tick(4);

        // single source 2: pending after 3 edges, request on the next
        push_exp(2'd2, 16'h0020);
        pulse_irq(4'b0100);
        tick(1);
        check("t1_pend_early", {28'd0, pending}, 32'h0);
        tick(1);
        check("t1_pend",       {28'd0, pending}, 32'h4);
        check("t1_int_low",    {31'd0, interrupt}, 32'd0);
        tick(1);
        check("t1_int_high",   {31'd0, interrupt}, 32'd1);
        do_ack();
        check("t1_insvc",      {31'd0, in_service}, 32'd1);
        check("t1_int_ack",    {31'd0, interrupt},  32'd0);
        check("t1_pend_clr",   {28'd0, pending},    32'h0);
        do_done();
        check("t1_insvc_off",  {31'd0, in_service}, 32'd0);

        // simultaneous 1 and 3: 1 first; stray int_done in REQ ignored
        push_exp(2'd1, 16'h0010);
        push_exp(2'd3, 16'h0030);
        pulse_irq(4'b1010);
        tick(2);
        check("t2_pend", {28'd0, pending}, 32'hA);
        tick(1);
        do_done();
        check("t2_done_ign_int", {31'd0, interrupt},  32'd1);
        check("t2_done_ign_svc", {31'd0, in_service}, 32'd0);
        check("t2_done_ign_id",  {30'd0, int_id},     32'd1);
        do_ack();
        check("t2_ack_svc",  {31'd0, in_service}, 32'd1);
        check("t2_ack_int",  {31'd0, interrupt},  32'd0);
        check("t2_ack_pend", {28'd0, pending},    32'h8);
        do_ack();
        check("t2_ack_in_svc_ign", {31'd0, in_service}, 32'd1);
        do_done();
        check("t2_idle_gap", {31'd0, interrupt}, 32'd0);
        tick(1);
        check("t2_second_req", {31'd0, interrupt}, 32'd1);
        do_ack();
        do_done();

        // masked source pends but is not selected until unmasked
        write_mask(4'b0001);
        pulse_irq(4'b0001);
        tick(2);
        check("t3_pend", {28'd0, pending}, 32'h1);
        tick(3);
        check("t3_masked_int", {31'd0, interrupt}, 32'd0);
        push_exp(2'd0, 16'h0000);
        write_mask(4'b0000);
        check("t3_unmask_wait", {31'd0, interrupt}, 32'd0);
        tick(1);
        check("t3_unmask_int", {31'd0, interrupt}, 32'd1);
        do_ack();
        do_done();

        // new edge on source 1 lands on the ack edge that clears it
        push_exp(2'd1, 16'h0010);
        pulse_irq(4'b0010);
        tick(3);
        @(negedge clk) irq_in = 4'b0010;
        @(negedge clk) irq_in = 4'b0000;
        @(negedge clk) int_ack = 1'b1;
        @(negedge clk) int_ack = 1'b0;
        check("t4_pend_kept", {28'd0, pending},    32'h2);
        check("t4_svc",       {31'd0, in_service}, 32'd1);
        push_exp(2'd1, 16'h0010);
        do_done();
        tick(1);
        check("t4_reserve", {31'd0, interrupt}, 32'd1);
        do_ack();
        do_done();

        // reset during SERVICE with source 2 held high
        push_exp(2'd2, 16'h0020);
        @(negedge clk) irq_in = 4'b0100;
        tick(3);
        do_ack();
        check("t5_svc", {31'd0, in_service}, 32'd1);
        @(negedge clk) reset = 1'b0;
        tick(1);
        check_reset_vals("t5_rst");
        @(negedge clk) reset = 1'b1;
        tick(10);
        check("t5_no_repend", {28'd0, pending},   32'h0);
        check("t5_no_int",    {31'd0, interrupt}, 32'd0);
        @(negedge clk) irq_in = 4'b0000;
        tick(3);
        push_exp(2'd2, 16'h0020);
        @(negedge clk) irq_in = 4'b0100;
        tick(3);
        check("t5_repend", {28'd0, pending}, 32'h4);
        tick(1);
        check("t5_req", {31'd0, interrupt}, 32'd1);
        do_ack();
        do_done();
        // level still high: no second pend
        tick(6);
        check("t5_level_once_pend", {28'd0, pending},   32'h0);
        check("t5_level_once_int",  {31'd0, interrupt}, 32'd0);
        irq_in = 4'b0000;
        tick(2);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
